// File: rtl/hdlc_rx_controller.sv
// HDLC receive frame controller: tracks frame boundaries, drives buffer writes and FCS
// handshakes, and holds good frames until the host reads or drops them.
module hdlc_rx_controller #(
   parameter int MAX_BYTES = 128,
   parameter int CW        = $clog2(MAX_BYTES + 1)
) (
   input  logic          Clk,
   input  logic          Rst,
   input  logic          RxEnable,
   input  logic          FlagDetect,
   input  logic          AbortDetect,
   input  logic          NewByte,
   input  logic          PartialByte,
   input  logic          FCSDone,
   input  logic          FCSerr,
   input  logic          ReadDone,
   input  logic          DropFrame,
   output logic          ValidFrame,
   output logic          WrBuff,
   output logic          StartFCS,
   output logic          EndFCS,
   output logic          EoF,
   output logic          Ready,
   output logic [CW-1:0] FrameSize,
   output logic          FrameError,
   output logic          Overflow,
   output logic          AbortSignal
);

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      OPEN  = 3'd1,
      RECV  = 3'd2,
      CHECK = 3'd3,
      HOLD  = 3'd4
   } state_t;

   localparam logic [CW-1:0] MAX_CNT = CW'(MAX_BYTES);
   localparam logic [CW-1:0] MIN_CNT = CW'(3);

   state_t        state_r, state_s;
   logic [CW-1:0] byte_count_r, byte_count_s;
   logic [CW-1:0] frame_size_r, frame_size_s;
   logic          valid_frame_r, valid_frame_s;
   logic          wr_buff_r, wr_buff_s;
   logic          start_fcs_r, start_fcs_s;
   logic          end_fcs_r, end_fcs_s;
   logic          eof_r, eof_s;
   logic          ready_r, ready_s;
   logic          frame_error_r, frame_error_s;
   logic          overflow_r, overflow_s;
   logic          abort_r, abort_s;
   logic          short_s;

   // Closing flag on a frame too short for an FCS or with leftover bits is a bad frame.
   assign short_s = (byte_count_r < MIN_CNT) || PartialByte;

   // State register
   always_ff @(posedge Clk) begin
      if (Rst) begin
         state_r <= IDLE;
      end else begin
         state_r <= state_s;
      end
   end

   // Next-state logic; in RECV abort beats flag beats data
   always_comb begin
      state_s = state_r;
      case (state_r)
         IDLE: begin
            if (FlagDetect && RxEnable) state_s = OPEN;
            else                        state_s = IDLE;
         end
         OPEN: begin
            if (!RxEnable)                      state_s = IDLE;
            else if (FlagDetect || AbortDetect) state_s = OPEN;
            else if (NewByte)                   state_s = RECV;
            else                                state_s = OPEN;
         end
         RECV: begin
            if (!RxEnable)       state_s = IDLE;
            else if (AbortDetect) state_s = IDLE;
            else if (FlagDetect) begin
               if (short_s) state_s = OPEN;
               else         state_s = CHECK;
            end else              state_s = RECV;
         end
         CHECK: begin
            if (FCSDone) begin
               if (FCSerr || overflow_r) state_s = OPEN;
               else                      state_s = HOLD;
            end else begin
               state_s = CHECK;
            end
         end
         HOLD: begin
            if (ReadDone || DropFrame) state_s = IDLE;
            else                       state_s = HOLD;
         end
         default: state_s = IDLE;
      endcase
   end

   // Output logic: next values of the registered outputs and byte counter
   always_comb begin
      byte_count_s  = byte_count_r;
      frame_size_s  = frame_size_r;
      ready_s       = ready_r;
      frame_error_s = frame_error_r;
      overflow_s    = overflow_r;
      abort_s       = abort_r;
      wr_buff_s     = 1'b0;
      start_fcs_s   = 1'b0;
      end_fcs_s     = 1'b0;
      eof_s         = 1'b0;
      valid_frame_s = (state_s == RECV);
      case (state_r)
         OPEN: begin
            if (state_s == RECV) begin
               byte_count_s  = CW'(1);
               wr_buff_s     = 1'b1;
               start_fcs_s   = 1'b1;
               frame_error_s = 1'b0;
               overflow_s    = 1'b0;
               abort_s       = 1'b0;
            end else begin
               byte_count_s  = byte_count_r;
            end
         end
         RECV: begin
            if (!RxEnable) begin
               eof_s = 1'b0;
            end else if (AbortDetect) begin
               abort_s = 1'b1;
               eof_s   = 1'b1;
            end else if (FlagDetect) begin
               if (short_s) begin
                  frame_error_s = 1'b1;
                  eof_s         = 1'b1;
               end else begin
                  end_fcs_s     = 1'b1;
               end
            end else if (NewByte) begin
               if (byte_count_r < MAX_CNT) begin
                  byte_count_s = byte_count_r + CW'(1);
                  wr_buff_s    = 1'b1;
               end else begin
                  overflow_s   = 1'b1;
               end
            end else begin
               eof_s = 1'b0;
            end
         end
         CHECK: begin
            if (FCSDone) begin
               eof_s = 1'b1;
               if (FCSerr) begin
                  frame_error_s = 1'b1;
               end else if (overflow_r) begin
                  ready_s       = 1'b0;
               end else begin
                  ready_s       = 1'b1;
                  frame_size_s  = byte_count_r - CW'(2);
               end
            end else begin
               eof_s = 1'b0;
            end
         end
         HOLD: begin
            if (ReadDone || DropFrame) begin
               ready_s      = 1'b0;
               frame_size_s = '0;
            end else begin
               ready_s      = 1'b1;
            end
         end
         default: begin
            eof_s = 1'b0;
         end
      endcase
   end

   // Output and counter registers
   always_ff @(posedge Clk) begin
      if (Rst) begin
         byte_count_r  <= '0;
         frame_size_r  <= '0;
         valid_frame_r <= 1'b0;
         wr_buff_r     <= 1'b0;
         start_fcs_r   <= 1'b0;
         end_fcs_r     <= 1'b0;
         eof_r         <= 1'b0;
         ready_r       <= 1'b0;
         frame_error_r <= 1'b0;
         overflow_r    <= 1'b0;
         abort_r       <= 1'b0;
      end else begin
         byte_count_r  <= byte_count_s;
         frame_size_r  <= frame_size_s;
         valid_frame_r <= valid_frame_s;
         wr_buff_r     <= wr_buff_s;
         start_fcs_r   <= start_fcs_s;
         end_fcs_r     <= end_fcs_s;
         eof_r         <= eof_s;
         ready_r       <= ready_s;
         frame_error_r <= frame_error_s;
         overflow_r    <= overflow_s;
         abort_r       <= abort_s;
      end
   end

   assign ValidFrame  = valid_frame_r;
   assign WrBuff      = wr_buff_r;
   assign StartFCS    = start_fcs_r;
   assign EndFCS      = end_fcs_r;
   assign EoF         = eof_r;
   assign Ready       = ready_r;
   assign FrameSize   = frame_size_r;
   assign FrameError  = frame_error_r;
   assign Overflow    = overflow_r;
   assign AbortSignal = abort_r;

endmodule

// File: tb/tb_hdlc_rx_controller.sv
// Self-checking bench for hdlc_rx_controller: expected end-of-frame status is queued
// as stimulus is driven and compared when the DUT pulses EoF.
module tb_hdlc_rx_controller;

   localparam int MAX_BYTES = 8;
   localparam int CW        = $clog2(MAX_BYTES + 1);

   logic          Clk = 1'b0;
   logic          Rst = 1'b1;
   logic          RxEnable = 1'b0;
   logic          FlagDetect = 1'b0;
   logic          AbortDetect = 1'b0;
   logic          NewByte = 1'b0;
   logic          PartialByte = 1'b0;
   logic          FCSDone = 1'b0;
   logic          FCSerr = 1'b0;
   logic          ReadDone = 1'b0;
   logic          DropFrame = 1'b0;
   logic          ValidFrame, WrBuff, StartFCS, EndFCS, EoF, Ready;
   logic [CW-1:0] FrameSize;
   logic          FrameError, Overflow, AbortSignal;

   int n_checks = 0;
   int n_fail   = 0;
   int q_eof[$];
   int wr_cnt = 0;
   int start_cnt = 0;
   int w0, s0;

   hdlc_rx_controller #(.MAX_BYTES(MAX_BYTES)) dut (
      .Clk(Clk), .Rst(Rst), .RxEnable(RxEnable), .FlagDetect(FlagDetect),
      .AbortDetect(AbortDetect), .NewByte(NewByte), .PartialByte(PartialByte),
      .FCSDone(FCSDone), .FCSerr(FCSerr), .ReadDone(ReadDone), .DropFrame(DropFrame),
      .ValidFrame(ValidFrame), .WrBuff(WrBuff), .StartFCS(StartFCS), .EndFCS(EndFCS),
      .EoF(EoF), .Ready(Ready), .FrameSize(FrameSize), .FrameError(FrameError),
      .Overflow(Overflow), .AbortSignal(AbortSignal)
   );

   always #5 Clk = ~Clk;

   task automatic check_eq(input string tag, input int obs, input int exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   function automatic int status(input int fe, input int ov, input int ab, input int rdy, input int size);
      return (fe << 12) | (ov << 11) | (ab << 10) | (rdy << 9) | size;
   endfunction

   // Scoreboard monitor: count write/start pulses and compare status on each EoF
   always @(negedge Clk) begin
      if (!Rst) begin
         if (WrBuff)   wr_cnt++;
         if (StartFCS) start_cnt++;
         if (EoF) begin
            if (q_eof.size() == 0) check_eq("eof_unexpected", 1, 0);
            else check_eq("eof_status",
                          status(int'(FrameError), int'(Overflow), int'(AbortSignal),
                                 int'(Ready), int'(FrameSize)),
                          q_eof.pop_front());
         end
      end
   end

   task automatic step(input logic f, input logic a, input logic nb);
      FlagDetect = f; AbortDetect = a; NewByte = nb;
      @(posedge Clk); #1;
      FlagDetect = 1'b0; AbortDetect = 1'b0; NewByte = 1'b0;
   endtask

   task automatic bytes(input int n);
      repeat (n) step(1'b0, 1'b0, 1'b1);
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(posedge Clk); #1;
      end
   endtask

   task automatic fcs(input logic err);
      FCSDone = 1'b1; FCSerr = err;
      @(posedge Clk); #1;
      FCSDone = 1'b0; FCSerr = 1'b0;
   endtask

   task automatic host(input logic rd, input logic drop);
      ReadDone = rd; DropFrame = drop;
      @(posedge Clk); #1;
      ReadDone = 1'b0; DropFrame = 1'b0;
   endtask

   function automatic int all_outputs();
      return int'({ValidFrame, WrBuff, StartFCS, EndFCS, EoF, Ready, FrameSize,
                   FrameError, Overflow, AbortSignal});
   endfunction

   initial begin
      repeat (2) @(posedge Clk);
      #1;
      check_eq("reset_outputs", all_outputs(), 0);
      Rst = 1'b0; RxEnable = 1'b1;
      idle(1);

      // good frame: 6 bytes -> size 4
      w0 = wr_cnt; s0 = start_cnt;
      step(1'b1, 1'b0, 1'b0);
      step(1'b0, 1'b0, 1'b1);
      check_eq("good_valid", int'(ValidFrame), 1);
      check_eq("good_start", int'(StartFCS), 1);
      bytes(5);
      step(1'b1, 1'b0, 1'b0);
      check_eq("good_endfcs", int'(EndFCS), 1);
      check_eq("good_valid_off", int'(ValidFrame), 0);
      q_eof.push_back(status(0, 0, 0, 1, 4));
      fcs(1'b0);
      check_eq("good_ready", int'(Ready), 1);
      check_eq("good_size", int'(FrameSize), 4);
      idle(1);
      check_eq("good_wr_count", wr_cnt - w0, 6);
      check_eq("good_start_count", start_cnt - s0, 1);
      host(1'b1, 1'b0);
      check_eq("read_ready", int'(Ready), 0);
      check_eq("read_size", int'(FrameSize), 0);
      step(1'b0, 1'b0, 1'b1);
      check_eq("idle_no_wr", int'(WrBuff), 0);

      // FCS error, then the next frame clears FrameError and ends short
      step(1'b1, 1'b0, 1'b0);
      bytes(6);
      step(1'b1, 1'b0, 1'b0);
      q_eof.push_back(status(1, 0, 0, 0, 0));
      fcs(1'b1);
      check_eq("fcserr_fe", int'(FrameError), 1);
      check_eq("fcserr_ready", int'(Ready), 0);
      step(1'b0, 1'b0, 1'b1);
      check_eq("next_clears_fe", int'(FrameError), 0);
      step(1'b0, 1'b0, 1'b1);
      q_eof.push_back(status(1, 0, 0, 0, 0));
      step(1'b1, 1'b0, 1'b0);
      check_eq("short_no_endfcs", int'(EndFCS), 0);
      check_eq("short_fe", int'(FrameError), 1);

      // non-octet frame: 4 bytes, closing flag with partial bits
      bytes(4);
      PartialByte = 1'b1;
      q_eof.push_back(status(1, 0, 0, 0, 0));
      step(1'b1, 1'b0, 1'b0);
      PartialByte = 1'b0;
      check_eq("partial_no_endfcs", int'(EndFCS), 0);

      // abort together with the 4th byte
      idle(1);
      w0 = wr_cnt;
      bytes(3);
      q_eof.push_back(status(0, 0, 1, 0, 0));
      step(1'b0, 1'b1, 1'b1);
      check_eq("abort_no_wr", int'(WrBuff), 0);
      check_eq("abort_sticky", int'(AbortSignal), 1);
      check_eq("abort_valid", int'(ValidFrame), 0);
      idle(1);
      check_eq("abort_wr_count", wr_cnt - w0, 3);
      step(1'b0, 1'b0, 1'b1);
      check_eq("abort_idle_no_wr", int'(WrBuff), 0);

      // overflow: 10 bytes into an 8-byte buffer
      idle(1);
      w0 = wr_cnt;
      step(1'b1, 1'b0, 1'b0);
      bytes(10);
      step(1'b1, 1'b0, 1'b0);
      check_eq("ovf_endfcs", int'(EndFCS), 1);
      q_eof.push_back(status(0, 1, 0, 0, 0));
      fcs(1'b0);
      idle(1);
      check_eq("ovf_wr_count", wr_cnt - w0, 8);
      check_eq("ovf_sticky", int'(Overflow), 1);
      check_eq("ovf_ready", int'(Ready), 0);

      // hold: good 5-byte frame, then line activity must not disturb it
      bytes(5);
      step(1'b1, 1'b0, 1'b0);
      q_eof.push_back(status(0, 0, 0, 1, 3));
      fcs(1'b0);
      w0 = wr_cnt;
      step(1'b1, 1'b0, 1'b0);
      bytes(5);
      step(1'b1, 1'b0, 1'b0);
      step(1'b0, 1'b1, 1'b0);
      idle(1);
      check_eq("hold_no_wr", wr_cnt - w0, 0);
      check_eq("hold_ready", int'(Ready), 1);
      check_eq("hold_size", int'(FrameSize), 3);
      host(1'b1, 1'b1);
      check_eq("both_ready", int'(Ready), 0);
      check_eq("both_size", int'(FrameSize), 0);

      // receiver disabled mid-frame: back to idle without EoF
      step(1'b1, 1'b0, 1'b0);
      bytes(2);
      RxEnable = 1'b0;
      idle(1);
      check_eq("disable_valid", int'(ValidFrame), 0);
      RxEnable = 1'b1;
      step(1'b0, 1'b0, 1'b1);
      check_eq("disable_no_wr", int'(WrBuff), 0);

      // reset mid-frame
      step(1'b1, 1'b0, 1'b0);
      bytes(2);
      Rst = 1'b1;
      idle(1);
      check_eq("rst_outputs", all_outputs(), 0);
      Rst = 1'b0;
      step(1'b0, 1'b0, 1'b1);
      check_eq("rst_idle_no_wr", int'(WrBuff), 0);

      idle(2);
      check_eq("eof_queue_empty", q_eof.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/hdlc_rx_controller.md
Name: hdlc_rx_controller

Overview:
Receive-side frame controller for the HDLC link; the counterpart to the TX controller. Sits between the RX bit channel (flag/abort/zero-destuff detection plus byte assembly) and the RX frame buffer/FCS checker. Tracks frame boundaries, writes received bytes to the RX buffer, starts FCS checking, and reports frame status: size, FCS error, overflow, abort, non-octet frame. Holds a good frame until the host reads or drops it.

Parameters:
MAX_BYTES, 128, RX buffer depth in bytes, FCS bytes included; must be ≥ 3.
CW, $clog2(MAX_BYTES+1), width of the byte counter and FrameSize.

Ports:
Clk  in  1  clock; one clock domain
Rst  in  1  reset; synchronous, active-high (Rst=1 at a posedge Clk resets)
RxEnable  in  1  receiver enabled (level)
FlagDetect  in  1  one-cycle pulse: 01111110 flag completed on line
AbortDetect  in  1  one-cycle pulse: 7 consecutive ones seen
NewByte  in  1  one-cycle pulse: destuffed data byte assembled
PartialByte  in  1  level: assembler holds 1-7 unconsumed bits (sampled on FlagDetect)
FCSDone  in  1  one-cycle pulse: FCS checker finished
FCSerr  in  1  FCS mismatch; valid only in the FCSDone cycle
ReadDone  in  1  pulse: host finished reading held frame
DropFrame  in  1  pulse: host discards held frame
ValidFrame  out  1  level: inside a frame (RECV state)
WrBuff  out  1  one-cycle pulse: write current RX byte into buffer
StartFCS  out  1  one-cycle pulse: first data byte of frame
EndFCS  out  1  one-cycle pulse: closing flag received, FCS result requested
EoF  out  1  one-cycle pulse: frame ended (good or bad)
Ready  out  1  level: good frame held in buffer
FrameSize  out  CW  payload bytes, FCS excluded; valid while Ready
FrameError  out  1  sticky: FCS error or frame too short/non-octet
Overflow  out  1  sticky: more than MAX_BYTES bytes received
AbortSignal  out  1  sticky: frame aborted

Behaviour:
- Reset: state IDLE, ByteCount=0, all outputs 0. Reset mid-frame discards the frame; no EoF.
- All outputs are registered. WrBuff/StartFCS/EndFCS/EoF are 1-cycle pulses, asserted the cycle after the causing input.
- States: IDLE, OPEN, RECV, CHECK, HOLD.
- IDLE: on FlagDetect && RxEnable, go to OPEN.
- OPEN (flag seen, no data yet):
  - FlagDetect: stay (back-to-back flags).
  - AbortDetect: stay; no status change.
  - NewByte: go to RECV. ByteCount=1, WrBuff=1, StartFCS=1, ValidFrame=1. Clear FrameError, Overflow and AbortSignal in the same cycle.
- RECV, input priority AbortDetect > FlagDetect > NewByte:
  - AbortDetect: AbortSignal=1, EoF pulse, ValidFrame=0, go to IDLE.
  - FlagDetect: ValidFrame=0. If ByteCount<3 or PartialByte, set FrameError, pulse EoF, go to OPEN (the closing flag opens the next frame). Otherwise pulse EndFCS and go to CHECK. A NewByte in the same cycle is not written.
  - NewByte with ByteCount<MAX_BYTES: increment ByteCount, pulse WrBuff.
  - NewByte with ByteCount==MAX_BYTES: no write, ByteCount saturates, Overflow=1.
- CHECK: ignore FlagDetect, AbortDetect and NewByte. On FCSDone, pulse EoF and apply the first matching rule:
  - FCSerr=1: FrameError=1, go to OPEN.
  - Overflow=1: go to OPEN.
  - Otherwise: Ready=1, FrameSize=ByteCount-2, go to HOLD.
- HOLD: line activity is ignored; the frame is not overwritten. ReadDone or DropFrame sets Ready=0 and FrameSize=0, then go to IDLE. If both pulse together, the result is identical.
- RxEnable=0 in OPEN or RECV: go to IDLE next cycle, no EoF, statuses unchanged. CHECK and HOLD are unaffected.
- Sticky statuses are cleared only by reset or by the next frame's StartFCS.

Test Plan:
- Good frame: flag, 6 NewBytes, flag, FCSDone with FCSerr=0 -> 6 WrBuff pulses, 1 StartFCS, EndFCS 1 cycle after the flag; then EoF, Ready=1, FrameSize=4. ReadDone -> Ready=0, state IDLE.
- FCS error: same frame with FCSerr=1 -> EoF, FrameError=1, Ready=0. Next frame's first NewByte clears FrameError.
- Short and non-octet frames: flag, 2 bytes, flag -> FrameError=1, no EndFCS. Flag, 4 bytes, flag with PartialByte=1 -> FrameError=1.
- Abort: AbortDetect after byte 3, asserted in the same cycle as NewByte -> no 4th WrBuff, AbortSignal=1, EoF, state IDLE.
- Overflow with MAX_BYTES=8: 10 bytes, flag, FCSDone -> exactly 8 WrBuff pulses, Overflow=1, Ready=0.
- Hold and reset: Ready=1, then a further flag and 5 bytes -> no WrBuff. Rst=1 in RECV -> next cycle all outputs 0, state IDLE.
